// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW scoreboard over EX/MEM/WR,
// taken-branch squash, memory-wait freeze with timeout, and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_regwr,
  input  logic [4:0]       id_rw,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             stage_en,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sb_v_q, sb_v_d;
  logic [2:0][4:0]   sb_rw_q, sb_rw_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              mem_err_q, mem_err_d;

  logic [2:0] rs_hit, rt_hit;
  logic       hz, timeout, frozen, br_flush, raw_stall, issue;

  // Slot 0 = EX, 1 = MEM, 2 = WR; WR is checked because the regfile write is not yet visible.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sb_cmp
      assign rs_hit[gi] = sb_v_q[gi] && (sb_rw_q[gi] == id_rs);
      assign rt_hit[gi] = sb_v_q[gi] && (sb_rw_q[gi] == id_rt);
    end
  endgenerate

  assign hz = id_valid && ((id_uses_rs && (id_rs != 5'd0) && (|rs_hit)) ||
                           (id_uses_rt && (id_rt != 5'd0) && (|rt_hit)));

  // A timeout releases the pipeline exactly like an ack.
  assign timeout   = (state_q == MEM_WAIT) && !mem_ack && (wait_cnt_q >= WC_W'(MEM_TIMEOUT));
  assign frozen    = ((state_q == RUN) && mem_req && !mem_ack) ||
                     ((state_q == MEM_WAIT) && !mem_ack && !timeout);
  assign br_flush  = !frozen && ex_branch_taken;
  assign raw_stall = !frozen && !ex_branch_taken && hz;
  assign issue     = !frozen && !ex_branch_taken && !hz;

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      sb_v_q     <= '0;
      sb_rw_q    <= '0;
      wait_cnt_q <= '0;
      stall_q    <= '0;
      flush_q    <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sb_v_q     <= sb_v_d;
      sb_rw_q    <= sb_rw_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sb_v_d     = sb_v_q;
    sb_rw_d    = sb_rw_q;
    wait_cnt_d = wait_cnt_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    mem_err_d  = mem_err_q;
    if (frozen) begin
      state_d    = MEM_WAIT;
      wait_cnt_d = (state_q == RUN) ? WC_W'(1) : wait_cnt_q + WC_W'(1);
      if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
    end else begin
      state_d    = RUN;
      wait_cnt_d = '0;
      if (timeout) mem_err_d = 1'b1;
      sb_v_d[2]  = sb_v_q[1];
      sb_v_d[1]  = sb_v_q[0];
      sb_rw_d[2] = sb_rw_q[1];
      sb_rw_d[1] = sb_rw_q[0];
      sb_rw_d[0] = id_rw;
      sb_v_d[0]  = issue && id_valid && id_regwr && (id_rw != 5'd0);
      if (br_flush && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
      if (raw_stall && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stage_en    = 1'b0;
    if (!rst_n) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (frozen) begin
      pc_en = 1'b0;
    end else if (br_flush) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      stage_en    = 1'b1;
    end else if (raw_stall) begin
      idex_bubble = 1'b1;
      stage_en    = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      stage_en = 1'b1;
    end
  end

  assign mem_err      = mem_err_q && rst_n;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; per-cycle expected control vectors go through a queue.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rs, id_uses_rt, id_regwr;
  logic [4:0] id_rs, id_rt, id_rw;
  logic       ex_branch_taken, mem_req, mem_ack;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble, stage_en, mem_err;
  logic [3:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  // {pc_en, ifid_en, ifid_flush, idex_bubble, stage_en}
  localparam logic [4:0] ISSUE = 5'b11001;
  localparam logic [4:0] RAW   = 5'b00011;
  localparam logic [4:0] BR    = 5'b11111;
  localparam logic [4:0] MEMS  = 5'b00000;
  localparam logic [4:0] RST   = 5'b00110;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwr(id_regwr), .id_rw(id_rw),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .stage_en(stage_en), .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt, input logic wr, input logic [4:0] rw);
    id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_regwr = wr; id_rw = rw;
  endtask

  task automatic idle();
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
  endtask

  // Inputs are set before the call; outputs sampled just after posedge, state moves on negedge.
  task automatic cyc(input string tag, input logic [4:0] ctrl, input logic err);
    logic [5:0] e;
    exp_q.push_back({ctrl, err});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, int'({pc_en, ifid_en, ifid_flush, idex_bubble, stage_en, mem_err}), int'(e));
    $display("cyc %s ctrl=%b mem_err=%b stall=%0d flush=%0d", tag,
             {pc_en, ifid_en, ifid_flush, idex_bubble, stage_en}, mem_err, stall_cycles, flush_count);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    idle();
    cyc("reset", RST, 1'b0);
    chk("reset_stall", int'(stall_cycles), 0);
    chk("reset_flush", int'(flush_count), 0);
    rst_n = 1'b1;

    // lw $2 then add $3,$2,$2
    instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2);
    cyc("lw", ISSUE, 1'b0);
    instr(1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3);
    for (int i = 0; i < 3; i++) cyc("add_raw", RAW, 1'b0);
    cyc("add_issue", ISSUE, 1'b0);
    chk("loaduse_stall", int'(stall_cycles), 3);
    idle();
    for (int i = 0; i < 3; i++) cyc("drain", ISSUE, 1'b0);

    // writes to $0 never hazard
    instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0);
    cyc("addi_r0", ISSUE, 1'b0);
    instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd4);
    cyc("read_r0", ISSUE, 1'b0);
    cyc("read_r0b", ISSUE, 1'b0);
    chk("r0_stall", int'(stall_cycles), 3);
    idle();
    for (int i = 0; i < 3; i++) cyc("drain", ISSUE, 1'b0);

    // taken branch beats a RAW hazard on the squashed ID instruction
    instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5);
    cyc("wr5", ISSUE, 1'b0);
    instr(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
    ex_branch_taken = 1'b1;
    cyc("branch", BR, 1'b0);
    ex_branch_taken = 1'b0;
    chk("branch_flush", int'(flush_count), 1);
    chk("branch_stall", int'(stall_cycles), 3);
    idle();
    for (int i = 0; i < 3; i++) cyc("drain", ISSUE, 1'b0);

    // memory wait, ack 4 cycles after req; scoreboard must be frozen meanwhile
    instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7);
    cyc("wr7", ISSUE, 1'b0);
    idle();
    mem_req = 1'b1;
    cyc("mreq", MEMS, 1'b0);
    mem_req = 1'b0;
    for (int i = 0; i < 3; i++) cyc("mwait", MEMS, 1'b0);
    mem_ack = 1'b1;
    cyc("mack", ISSUE, 1'b0);
    mem_ack = 1'b0;
    chk("mem_stall", int'(stall_cycles), 7);
    instr(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
    cyc("rd7_mem", RAW, 1'b0);
    cyc("rd7_wr", RAW, 1'b0);
    cyc("rd7_issue", ISSUE, 1'b0);
    chk("rd7_stall", int'(stall_cycles), 9);
    idle();

    // timeout: mem_req held high through the wait, no ack ever
    mem_req = 1'b1;
    cyc("to_req", MEMS, 1'b0);
    for (int i = 0; i < 7; i++) cyc("to_wait", MEMS, 1'b0);
    chk("to_stall_sat", int'(stall_cycles), 15);
    cyc("to_release", ISSUE, 1'b0);
    chk("to_err", int'(mem_err), 1);
    mem_req = 1'b0;
    cyc("after_to", ISSUE, 1'b1);
    cyc("after_to2", ISSUE, 1'b1);
    mem_req = 1'b1; mem_ack = 1'b1;
    cyc("req_ack_same", ISSUE, 1'b1);
    mem_req = 1'b0; mem_ack = 1'b0;
    chk("req_ack_stall", int'(stall_cycles), 15);

    // flush counter saturation
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 14; i++) cyc("br_sat", BR, 1'b1);
    chk("flush_15", int'(flush_count), 15);
    cyc("br_sat", BR, 1'b1);
    cyc("br_sat", BR, 1'b1);
    chk("flush_sat", int'(flush_count), 15);
    ex_branch_taken = 1'b0;

    // reset in the middle of MEM_WAIT
    instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9);
    cyc("wr9", ISSUE, 1'b1);
    idle();
    mem_req = 1'b1;
    cyc("rs_req", MEMS, 1'b1);
    mem_req = 1'b0;
    cyc("rs_wait", MEMS, 1'b1);
    rst_n = 1'b0;
    cyc("rs_reset", RST, 1'b0);
    rst_n = 1'b1;
    chk("rs_stall", int'(stall_cycles), 0);
    chk("rs_flush", int'(flush_count), 0);
    instr(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0);
    cyc("rs_rd9", ISSUE, 1'b0);
    chk("rs_stall2", int'(stall_cycles), 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipelined CPU (IF, ID, EX, MEM, WR). It drives the `IFstall`/`IDstall`-style enables and bubble/flush controls of the pipeline registers.
- It keeps a 3-entry destination scoreboard (EX, MEM, WR) for RAW hazard detection, since the datapath has no forwarding.
- It squashes wrong-path instructions on taken branches resolved in EX.
- It freezes the whole pipeline while a data-memory access is outstanding, and maintains stall and flush counters.

Parameters:
- MEM_TIMEOUT, 16, max MEM_WAIT cycles before abort; minimum legal value 1.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on negedge clk, matching the pipeline registers.
- rst_n  in  1  reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  5  ID source register A.
- id_rt  in  5  ID source register B.
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt.
- id_regwr  in  1  instruction writes the register file.
- id_rw  in  5  destination register after the RegDst mux.
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- mem_req  in  1  MEM stage starts a data-memory access.
- mem_ack  in  1  memory completes the access.
- pc_en  out  1  PC may update.
- ifid_en  out  1  IF/ID register loads.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads a NOP with all control bits 0.
- stage_en  out  1  EX/MEM and MEM/WR registers and the PC-side branch path advance.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cycles  out  CNT_W  count of RAW plus memory stall cycles.
- flush_count  out  CNT_W  count of taken-branch flushes.

Behaviour:
- Reset: one clock, reset is synchronous and active-low (rst_n sampled on the active clk edge).
  - While rst_n=0: pc_en=0, ifid_en=0, stage_en=0, ifid_flush=1, idex_bubble=1, mem_err=0.
  - Reset clears the scoreboard, state=RUN, wait counter=0, and both counters=0.
  - Reset asserted in any state, including MEM_WAIT, aborts immediately, with no mem_err.
- Control outputs are combinational from state, scoreboard and inputs, so they act in the same cycle. Counters and mem_err are registered.
- Scoreboard: 3 slots, each {v, rw}: SB_EX, SB_MEM, SB_WR.
  - The register file write in WR is not visible to ID until the next cycle, so all 3 slots are checked.
  - Hazard `hz` = id_valid & ((id_uses_rs & id_rs≠0 & id_rs matches a valid slot) | (id_uses_rt & id_rt≠0 & id_rt matches a valid slot)).
  - Register $0 never causes a hazard.
- FSM states: RUN and MEM_WAIT. Priority within RUN is memory stall > branch flush > RAW stall > issue.
- RUN, mem_req & !mem_ack:
  - All enables are 0, with no bubble and no flush.
  - Next state is MEM_WAIT; wait counter=1; stall_cycles+1.
- RUN, mem_req & mem_ack in the same cycle: no stall; evaluate the lower-priority cases normally.
- RUN, ex_branch_taken:
  - pc_en=1 (PC loads the target), ifid_flush=1, idex_bubble=1, stage_en=1.
  - Scoreboard shifts with a v=0 entry into SB_EX.
  - flush_count+1. A hazard on the squashed ID instruction is ignored.
- RUN, hz:
  - pc_en=0, ifid_en=0, idex_bubble=1, stage_en=1.
  - Scoreboard shifts with v=0 into SB_EX; stall_cycles+1.
- RUN, issue:
  - pc_en=1, ifid_en=1, stage_en=1.
  - Scoreboard shifts: SB_WR←SB_MEM, SB_MEM←SB_EX, SB_EX←{id_valid & id_regwr & id_rw≠0, id_rw}.
- MEM_WAIT:
  - All enables are 0; the scoreboard is frozen.
  - If mem_ack=0: stall_cycles+1 and wait counter+1.
  - If mem_ack=1: the release cycle is evaluated with the RUN rules (mem_req is ignored), and the next state is RUN.
  - If the wait counter reaches MEM_TIMEOUT without ack: set mem_err=1 (sticky until reset), then treat the cycle as an ack.
- A branch taken while frozen is held stable by the frozen EX stage and takes effect in the release cycle.
- Counters saturate at all-ones and do not wrap.

Test Plan:
- Sequence `lw $2` then `add $3,$2,$2`, back to back → idex_bubble=1 and pc_en=0 for exactly 3 cycles. The add issues on the 4th cycle; stall_cycles=3.
- `addi $0,...` followed by a reader of $0 → no stall; pc_en stays 1 every cycle.
- ex_branch_taken=1 with the ID instruction hazarding on the EX destination → ifid_flush=1, idex_bubble=1 and pc_en=1 in that cycle; flush_count=1; stall_cycles unchanged.
- mem_req=1 with mem_ack arriving 4 cycles later → stage_en=0 for cycles 0–3 and 1 on the ack cycle; stall_cycles=4; state returns to RUN; scoreboard contents are unchanged.
- MEM_TIMEOUT=8, mem_ack never asserted → mem_err rises after 8 wait cycles and the pipeline resumes; mem_err stays 1 through later traffic.
- rst_n=0 for one cycle in the middle of MEM_WAIT → reset output values hold; after release the state is RUN, counters are 0, mem_err=0, and a prior pending destination causes no stall.
